// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter feeding NUM_REQ single-shot requesters onto one APB bus with wait-state and timeout handling.
// Accept-to-response is 3 cycles plus wait states; req_ready is offered only while the bus is idle.
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] cand;
  logic             gnt_vld;
  logic [CNT_W-1:0] to_cnt;
  logic             timed_out;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!gnt_vld && req_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (state == IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // to_cnt holds the number of ACCESS cycles already elapsed before the current one.
  assign timed_out = (TIMEOUT != 0) && (to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_idx   <= '0;
      to_cnt    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            cur_idx <= gnt_idx;
            rr_ptr  <= IDX_W'((int'(gnt_idx) + 1) % NUM_REQ);
            paddr   <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            pwdata  <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            pwrite  <= req_write[gnt_idx];
            psel    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          to_cnt  <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_rdata          <= pwrite ? '0 : prdata;
            rsp_err            <= 1'b0;
            rsp_valid[cur_idx] <= 1'b1;
            psel               <= 1'b0;
            penable            <= 1'b0;
            state              <= IDLE;
          end else if (timed_out) begin
            rsp_rdata          <= '0;
            rsp_err            <= 1'b1;
            rsp_valid[cur_idx] <= 1'b1;
            psel               <= 1'b0;
            penable            <= 1'b0;
            state              <= IDLE;
          end else if (TIMEOUT != 0) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small APB slave model whose memory resets to word address.
// Slave inserts wait_req wait states per transfer; a huge wait_req models a hung slave.
module tb_apb_master_arbiter;

  logic        pclk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;

  int n_checks = 0;
  int n_fail   = 0;
  int wait_req = 0;
  int acc_cnt;
  int cyc      = 0;
  logic [31:0] mem [64];

  apb_master_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .pclk(pclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  // APB slave model
  assign pready = psel && penable && (acc_cnt >= wait_req);
  assign prdata = mem[paddr[7:2]];

  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i * 4);
    end else begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (psel && penable && pready && pwrite) mem[paddr[7:2]] <= pwdata;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge pclk);
    rst_n = 1'b1;
  endtask

  // One complete transfer from requester idx; checks phases, latency and response.
  task automatic xfer(input string tag, input int idx, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input int exp_lat, input int exp_acc,
                      input logic [31:0] exp_rd, input bit exp_err);
    int lat;
    int nacc;
    bit ok_setup;
    bit stable;
    bit got;
    req_write[idx]          = wr;
    req_addr[idx*32 +: 32]  = a;
    req_wdata[idx*32 +: 32] = d;
    req_valid[idx]          = 1'b1;
    #1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (req_ready[idx]) begin
        got = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    check({tag, "_ready"}, got, 1);
    @(posedge pclk);
    #1;
    req_valid[idx] = 1'b0;
    lat = 0; nacc = 0; ok_setup = 1'b0; stable = 1'b1;
    while (lat < 60) begin
      @(negedge pclk);
      lat++;
      if (lat == 1) ok_setup = psel && !penable && paddr == a && pwrite == wr && pwdata == d;
      if (psel && penable) begin
        nacc++;
        if (paddr != a || pwrite != wr || pwdata != d) stable = 1'b0;
      end
      if (rsp_valid != 0) break;
    end
    check({tag, "_setup"}, ok_setup, 1);
    check({tag, "_access_cycles"}, nacc, exp_acc);
    check({tag, "_bus_stable"}, stable, 1);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rsp_valid"}, rsp_valid, 2'b01 << idx);
    check({tag, "_rdata"}, rsp_rdata, exp_rd);
    check({tag, "_err"}, rsp_err, exp_err);
    check({tag, "_psel_idle"}, {psel, penable}, 0);
    @(negedge pclk);
    check({tag, "_pulse_len"}, rsp_valid, 0);
  endtask

  initial begin
    logic [1:0] exp_g [4];
    int  t_prev;
    bit  got;
    bit  rsp_seen;
    int  lat;
    rst_n     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_req_ready", req_ready, 0);
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;

    // Write then read back through requester 0
    xfer("t1w", 0, 1'b1, 32'h10, 32'hA5A50001, 3, 1, 32'h0, 1'b0);
    xfer("t1r", 0, 1'b0, 32'h10, 32'h0, 3, 1, 32'hA5A50001, 1'b0);

    // Read slave reset image through requester 1
    do_reset();
    xfer("t2", 1, 1'b0, 32'h20, 32'h0, 3, 1, 32'h20, 1'b0);

    // Both requesters held valid: round-robin 0,1,0,1, back-to-back every 3 cycles
    do_reset();
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    req_write = 2'b00;
    req_addr  = {32'h44, 32'h40};
    req_wdata = '0;
    req_valid = 2'b11;
    #1;
    t_prev = 0;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 20; k++) begin
        if (req_ready != 0) break;
        @(negedge pclk);
      end
      check($sformatf("t3_grant%0d", n), req_ready, exp_g[n]);
      if (n > 0) check($sformatf("t3_gap%0d", n), cyc - t_prev, 3);
      t_prev = cyc;
      @(posedge pclk);
      #1;
      if (n == 3) req_valid = 2'b00;
    end
    lat = 0;
    while (lat < 20 && rsp_valid == 0) begin
      @(negedge pclk);
      lat++;
    end
    check("t3_last_rsp", rsp_valid, 2'b10);
    check("t3_last_rdata", rsp_rdata, 32'h44);
    @(negedge pclk);

    // Three wait states
    wait_req = 3;
    xfer("t4", 1, 1'b1, 32'h30, 32'h5A5A1234, 6, 4, 32'h0, 1'b0);

    // Hung slave times out after 16 ACCESS cycles, then a normal transfer
    wait_req = 1000;
    xfer("t5", 0, 1'b0, 32'h20, 32'h0, 18, 16, 32'h0, 1'b1);
    wait_req = 0;
    xfer("t5n", 1, 1'b0, 32'h24, 32'h0, 3, 1, 32'h24, 1'b0);

    // Reset in the middle of ACCESS
    wait_req = 1000;
    req_write[0]     = 1'b1;
    req_addr[31:0]   = 32'h50;
    req_wdata[31:0]  = 32'h12345678;
    req_valid[0]     = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (req_ready[0]) break;
      @(negedge pclk);
    end
    @(posedge pclk);
    #1;
    req_valid[0] = 1'b0;
    repeat (2) @(negedge pclk);
    check("t6_in_access", {psel, penable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_bus", {psel, penable}, 0);
    wait_req  = 0;
    req_write = 2'b00;
    req_addr  = {32'h60, 32'h64};
    req_valid = 2'b11;
    rsp_seen  = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      if (rsp_valid != 0) rsp_seen = 1'b1;
    end
    rst_n = 1'b1;
    #1;
    if (rsp_valid != 0) rsp_seen = 1'b1;
    check("t6_no_rsp", rsp_seen, 0);
    check("t6_first_grant", req_ready, 2'b01);
    @(posedge pclk);
    #1;
    req_valid[0] = 1'b0;
    lat = 0;
    while (lat < 20 && rsp_valid == 0) begin
      @(negedge pclk);
      lat++;
    end
    check("t6_rsp0", rsp_valid, 2'b01);
    check("t6_rdata0", rsp_rdata, 32'h64);
    check("t6_grant1_same_cycle", req_ready, 2'b10);
    @(posedge pclk);
    #1;
    req_valid = 2'b00;
    lat = 0;
    while (lat < 20 && rsp_valid == 0) begin
      @(negedge pclk);
      lat++;
    end
    check("t6_rsp1", rsp_valid, 2'b10);
    check("t6_rdata1", rsp_rdata, 32'h60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
